// File: rtl/rv_ram_pipe.sv
// rv_ram_pipe: pipelined data RAM with request/grant handshake and a credit-limited response FIFO.
// Build macro RV_RAM_PIPE_ERR_EN enables error responses for misaligned or out-of-range addresses.
module rv_ram_pipe #(
   parameter int    XLEN       = 32,
   parameter int    DEPTH_LOG2 = 16,
   parameter int    LATENCY    = 3,
   parameter int    RSP_DEPTH  = 4,
   parameter string INIT_FILE  = ""
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              data_req_i,
   output logic              data_gnt_o,
   input  logic              data_we_i,
   input  logic [XLEN/8-1:0] data_be_i,
   input  logic [XLEN-1:0]   data_addr_i,
   input  logic [XLEN-1:0]   data_wdata_i,
   output logic              data_rvalid_o,
   input  logic              data_rready_i,
   output logic [XLEN-1:0]   data_rdata_o,
   output logic              data_err_o
);

   localparam int NB    = XLEN / 8;
   localparam int WORDS = 2 ** DEPTH_LOG2;
   localparam int PW    = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int CW    = $clog2(RSP_DEPTH + 1);

   logic [XLEN-1:0]       mem [WORDS];
   logic [DEPTH_LOG2-1:0] word_idx;
   logic                  accept;
   logic                  pop;
   logic                  req_err;
   logic [XLEN-1:0]       rsp_word;

   logic                  push_valid;
   logic                  push_err;
   logic [XLEN-1:0]       push_data;

   logic [XLEN-1:0]       fifo_data [RSP_DEPTH];
   logic [RSP_DEPTH-1:0]  fifo_err;
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [CW-1:0]         fifo_cnt;
   logic [CW-1:0]         cnt;

   assign word_idx = data_addr_i[DEPTH_LOG2+1:2];
   assign accept   = data_req_i && data_gnt_o;
   assign pop      = data_rvalid_o && data_rready_i;

`ifdef RV_RAM_PIPE_ERR_EN
   assign req_err = (data_addr_i[1:0] != 2'b00) || ((data_addr_i >> (DEPTH_LOG2 + 2)) != '0);
`else
   logic unused_addr;
   assign req_err     = 1'b0;
   assign unused_addr = ^data_addr_i;
`endif

   // Read data is sampled before the same-edge write lands; writes and errors answer with zero.
   assign rsp_word = (data_we_i || req_err) ? '0 : mem[word_idx];

   always_ff @(posedge clk_i) begin
      if (accept && data_we_i && !req_err) begin
         for (int b = 0; b < NB; b++) begin
            if (data_be_i[b]) mem[word_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
         end
      end
   end

   // The FIFO write itself is the last latency stage, so the shift pipeline is LATENCY-1 deep.
   generate
      if (LATENCY == 1) begin : g_nopipe
         assign push_valid = accept;
         assign push_err   = req_err;
         assign push_data  = rsp_word;
      end else begin : g_pipe
         localparam int PD = LATENCY - 1;
         logic [PD-1:0]   pipe_valid;
         logic [PD-1:0]   pipe_err;
         logic [XLEN-1:0] pipe_data [PD];

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               pipe_valid <= '0;
               pipe_err   <= '0;
            end else begin
               pipe_valid[0] <= accept;
               pipe_err[0]   <= req_err;
               pipe_data[0]  <= rsp_word;
               for (int i = 1; i < PD; i++) begin
                  pipe_valid[i] <= pipe_valid[i-1];
                  pipe_err[i]   <= pipe_err[i-1];
                  pipe_data[i]  <= pipe_data[i-1];
               end
            end
         end

         assign push_valid = pipe_valid[PD-1];
         assign push_err   = pipe_err[PD-1];
         assign push_data  = pipe_data[PD-1];
      end
   endgenerate

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Credits guarantee a free slot for every push, so no full check is needed here.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push_valid) begin
            fifo_data[wr_ptr] <= push_data;
            fifo_err[wr_ptr]  <= push_err;
            wr_ptr            <= ptr_inc(wr_ptr);
         end
         if (pop) rd_ptr <= ptr_inc(rd_ptr);
         case ({push_valid, pop})
            2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
            2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt <= '0;
      end else begin
         case ({accept, pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   assign data_gnt_o    = !rst_i && (cnt < CW'(RSP_DEPTH));
   assign data_rvalid_o = (fifo_cnt != '0);
   assign data_rdata_o  = data_rvalid_o ? fifo_data[rd_ptr] : '0;
   assign data_err_o    = data_rvalid_o && fifo_err[rd_ptr];

endmodule

// File: tb/tb_rv_ram_pipe.sv
// tb_rv_ram_pipe: directed and random stimulus for rv_ram_pipe against a transaction-level model
// (memory array plus an in-order queue of expected responses with their acceptance cycles).
module tb_rv_ram_pipe;

   localparam int XLEN       = 32;
   localparam int DEPTH_LOG2 = 8;
   localparam int LATENCY    = 3;
   localparam int RSP_DEPTH  = 4;
   localparam int WORDS      = 2 ** DEPTH_LOG2;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        data_req_i = 1'b0;
   logic        data_gnt_o;
   logic        data_we_i = 1'b0;
   logic [3:0]  data_be_i = 4'h0;
   logic [31:0] data_addr_i = '0;
   logic [31:0] data_wdata_i = '0;
   logic        data_rvalid_o;
   logic        data_rready_i = 1'b0;
   logic [31:0] data_rdata_o;
   logic        data_err_o;

   rv_ram_pipe #(
      .XLEN(XLEN), .DEPTH_LOG2(DEPTH_LOG2), .LATENCY(LATENCY), .RSP_DEPTH(RSP_DEPTH), .INIT_FILE("")
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_we_i(data_we_i),
      .data_be_i(data_be_i), .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
      .data_rvalid_o(data_rvalid_o), .data_rready_i(data_rready_i),
      .data_rdata_o(data_rdata_o), .data_err_o(data_err_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        err;
      logic [31:0] data;
      int          acc;
   } rsp_t;

   rsp_t        exp_q[$];
   logic [31:0] mem_model [WORDS];
   int          cmp_cnt = 0;
   int          err_cnt = 0;
   int          cyc = 0;
   int          last_pop = -1;
   int          acc_cnt = 0;
   logic        last_v, last_gnt, last_acc;
   logic [31:0] last_pop_rdata;
   logic        last_pop_err;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      cmp_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("[TB] FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic model_err(input logic [31:0] addr);
`ifdef RV_RAM_PIPE_ERR_EN
      return (addr % 4 != 0) || (addr >= 32'(4 * WORDS));
`else
      return 1'b0;
`endif
   endfunction

   // One clock cycle: drive inputs, check outputs against the model, then advance the model.
   task automatic apply_stimulus(input logic req, input logic we, input logic [3:0] be,
                                 input logic [31:0] addr, input logic [31:0] wdata, input logic rdy);
      logic g, v, exp_v, e;
      int   idx;
      rsp_t r;
      data_req_i = req; data_we_i = we; data_be_i = be;
      data_addr_i = addr; data_wdata_i = wdata; data_rready_i = rdy;
      #1;
      g = data_gnt_o;
      v = data_rvalid_o;
      exp_v = (exp_q.size() > 0) && (cyc >= exp_q[0].acc + LATENCY) && (cyc > last_pop);
      check_output("gnt", 32'(g), 32'(exp_q.size() < RSP_DEPTH));
      check_output("rvalid", 32'(v), 32'(exp_v));
      if (v && exp_q.size() > 0) begin
         check_output("rdata", data_rdata_o, exp_q[0].data);
         check_output("err", 32'(data_err_o), 32'(exp_q[0].err));
      end
      last_v = v;
      last_gnt = g;
      last_acc = req && g;
      if (v && rdy) begin
         last_pop_rdata = data_rdata_o;
         last_pop_err = data_err_o;
         if (exp_q.size() > 0) void'(exp_q.pop_front());
         last_pop = cyc;
      end
      if (req && g) begin
         idx = int'((addr / 4) % WORDS);
         e = model_err(addr);
         r.err = e;
         r.acc = cyc;
         r.data = (we || e) ? 32'h0 : mem_model[idx];
         exp_q.push_back(r);
         if (we && !e) begin
            for (int b = 0; b < 4; b++) begin
               if (be[b]) mem_model[idx][8*b +: 8] = wdata[8*b +: 8];
            end
         end
         acc_cnt++;
      end
      @(posedge clk_i);
      #1;
      cyc++;
   endtask

   task automatic issue(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic rdy);
      int n = 0;
      do begin
         apply_stimulus(1'b1, we, be, addr, wdata, rdy);
         n++;
      end while (!last_acc && n < 20);
      if (!last_acc) check_output("issue_timeout", 32'(last_acc), 32'd1);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() > 0 && n < 50) begin
         apply_stimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
         n++;
      end
      check_output("drain_left", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic do_reset();
      data_req_i = 1'b0;
      data_rready_i = 1'b0;
      rst_i = 1'b1;
      #1;
      check_output("rst_gnt_during", 32'(data_gnt_o), 32'd0);
      @(posedge clk_i);
      #1;
      cyc++;
      exp_q.delete();
      check_output("rst_gnt", 32'(data_gnt_o), 32'd0);
      check_output("rst_rvalid", 32'(data_rvalid_o), 32'd0);
      check_output("rst_rdata", data_rdata_o, 32'd0);
      check_output("rst_err", 32'(data_err_o), 32'd0);
      @(posedge clk_i);
      #1;
      cyc++;
      rst_i = 1'b0;
   endtask

   initial begin
      int          acc0, low, n;
      logic [31:0] d;

      do_reset();

      // Preload every word so that later random reads are fully defined.
      for (int i = 0; i < WORDS; i++) begin
         d = $urandom;
         issue(1'b1, 4'hF, 32'(i * 4), d, 1'b1);
      end
      drain();

      // Write then read with exact latency.
      issue(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b1);
      apply_stimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
      check_output("wr_lat_c1", 32'(last_v), 32'd0);
      apply_stimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
      check_output("wr_lat_c2", 32'(last_v), 32'd0);
      apply_stimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
      check_output("wr_lat_c3", 32'(last_v), 32'd1);
      check_output("wr_rsp_data", last_pop_rdata, 32'h0);
      issue(1'b0, 4'h0, 32'h10, 32'h0, 1'b1);
      apply_stimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
      apply_stimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
      check_output("rd_lat_c2", 32'(last_v), 32'd0);
      apply_stimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
      check_output("rd_lat_c3", 32'(last_v), 32'd1);
      check_output("rd_data", last_pop_rdata, 32'hDEADBEEF);

      // Byte lanes.
      issue(1'b1, 4'hF, 32'h20, 32'h11223344, 1'b1);
      issue(1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, 1'b1);
      issue(1'b0, 4'h0, 32'h20, 32'h0, 1'b1);
      drain();
      check_output("byte_lane", last_pop_rdata, 32'h11BB33DD);

`ifdef RV_RAM_PIPE_ERR_EN
      issue(1'b1, 4'hF, 32'h13, 32'h55555555, 1'b1);
      drain();
      check_output("err_wr_flag", 32'(last_pop_err), 32'd1);
      issue(1'b0, 4'h0, 32'h13, 32'h0, 1'b1);
      drain();
      check_output("err_rd_flag", 32'(last_pop_err), 32'd1);
      check_output("err_rd_data", last_pop_rdata, 32'h0);
      issue(1'b0, 4'h0, 32'(4 * WORDS), 32'h0, 1'b1);
      drain();
      check_output("err_oob_flag", 32'(last_pop_err), 32'd1);
      check_output("err_oob_data", last_pop_rdata, 32'h0);
      issue(1'b0, 4'h0, 32'h10, 32'h0, 1'b1);
      drain();
      check_output("err_no_write", last_pop_rdata, 32'hDEADBEEF);
`endif

      // Backpressure: burst with rready low fills exactly RSP_DEPTH credits.
      acc0 = acc_cnt;
      for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 1'b0, 4'h0, 32'(64 + i * 4), 32'h0, 1'b0);
      check_output("bp_accepts", 32'(acc_cnt - acc0), 32'(RSP_DEPTH));
      check_output("bp_gnt_full", 32'(last_gnt), 32'd0);
      apply_stimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
      apply_stimulus(1'b1, 1'b0, 4'h0, 32'h200, 32'h0, 1'b0);
      check_output("bp_gnt_after_pop", 32'(last_gnt), 32'd1);
      drain();

      // Streaming reads with rready held high.
      acc0 = acc_cnt;
      low = 0;
      n = 0;
      while ((acc_cnt - acc0) < 100 && n < 200) begin
         apply_stimulus(1'b1, 1'b0, 4'h0, 32'(((acc_cnt - acc0) % WORDS) * 4), 32'h0, 1'b1);
         if (!last_gnt) low++;
         n++;
      end
      check_output("stream_accepts", 32'(acc_cnt - acc0), 32'd100);
      check_output("stream_gnt_low", 32'(low), 32'd0);
      drain();

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         d = ($urandom_range(0, 3) == 0) ? $urandom : (32'($urandom_range(0, WORDS - 1)) << 2);
         apply_stimulus($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, 4'($urandom),
                        d, $urandom, $urandom_range(0, 9) < 7);
      end
      drain();

      // Reset with three responses queued; memory must survive.
      issue(1'b1, 4'hF, 32'h80, 32'hCAFEF00D, 1'b1);
      drain();
      for (int i = 0; i < 3; i++) issue(1'b0, 4'h0, 32'(i * 4), 32'h0, 1'b0);
      for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
      check_output("mid_queued", 32'(last_v), 32'd1);
      do_reset();
      apply_stimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
      check_output("post_rst_rvalid", 32'(last_v), 32'd0);
      check_output("post_rst_gnt", 32'(last_gnt), 32'd1);
      issue(1'b0, 4'h0, 32'h80, 32'h0, 1'b1);
      drain();
      check_output("post_rst_mem", last_pop_rdata, 32'hCAFEF00D);

      $display("[TB] done after %0d cycles", cyc);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
